// File: rtl/stream_result_checker.sv
// Beat-by-beat comparator of a DUT stream against an expected stream, with stall timeout and sticky pass/fail verdict.
// Optional macro STREAM_RESULT_CHECKER_STOP_ON_ERROR_EN ends the run on the first mismatching beat.
module stream_result_checker #(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_beats,
  input  logic              dut_valid,
  output logic              dut_ready,
  input  logic [DATA_W-1:0] dut_data,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              pass,
  output logic              fail,
  output logic              timeout_flag
);

  localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   num_beats_q;
  logic [CNT_W-1:0]   beat_d, err_d;
  logic [STALL_W-1:0] stall, stall_d;
  logic               pass_d, fail_d, timeout_d;
  logic               load, beat, mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign beat      = (state == RUN) & dut_valid & exp_valid;
  assign dut_ready = beat;
  assign exp_ready = beat;
  assign busy      = (state == RUN);

  // Written as if/else so unknown data falls into the mismatch branch in simulation.
  always_comb begin
    if (dut_data == exp_data) mismatch = 1'b0;
    else                      mismatch = 1'b1;
  end

  always_comb begin
    state_d   = state;
    beat_d    = beat_count;
    err_d     = err_count;
    stall_d   = stall;
    pass_d    = pass;
    fail_d    = fail;
    timeout_d = timeout_flag;
    load      = 1'b0;
    case (state)
      RUN: begin
        if (beat) begin
          beat_d  = beat_count + CNT_W'(1);
          stall_d = '0;
          if (mismatch) err_d = sat_inc(err_count);
          if (beat_d == num_beats_q) begin
            if (err_d == '0) begin
              state_d = PASS;
              pass_d  = 1'b1;
            end else begin
              state_d = FAIL;
              fail_d  = 1'b1;
            end
          end
`ifdef STREAM_RESULT_CHECKER_STOP_ON_ERROR_EN
          else if (mismatch) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end
`endif
        end else if (stall == STALL_LAST) begin
          state_d   = FAIL;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          stall_d = stall + STALL_W'(1);
        end
      end
      default: begin
        if (start) begin
          load      = 1'b1;
          beat_d    = '0;
          err_d     = '0;
          stall_d   = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          if (num_beats == '0) begin
            state_d = PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_count   <= '0;
      err_count    <= '0;
      stall        <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_d;
      beat_count   <= beat_d;
      err_count    <= err_d;
      stall        <= stall_d;
      pass         <= pass_d;
      fail         <= fail_d;
      timeout_flag <= timeout_d;
    end
  end

  // Beat target is captured only when a run is accepted; no reset needed.
  always_ff @(posedge clk) begin
    if (load) num_beats_q <= num_beats;
  end

endmodule

// File: tb/tb_stream_result_checker.sv
// Directed and randomized bench for stream_result_checker against a cycle-level scoreboard model.
module tb_stream_result_checker;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int TO = 20;
`ifdef STREAM_RESULT_CHECKER_STOP_ON_ERROR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, dut_valid, exp_valid;
  logic [CW-1:0] num_beats;
  logic [DW-1:0] dut_data, exp_data;
  logic          dut_ready, exp_ready, busy, pass, fail, timeout_flag;
  logic [CW-1:0] beat_count, err_count;

  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [DW-1:0] dq[64];
  logic [DW-1:0] eq[64];

  stream_result_checker #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_beats(num_beats),
    .dut_valid(dut_valid), .dut_ready(dut_ready), .dut_data(dut_data),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .busy(busy), .beat_count(beat_count), .err_count(err_count),
    .pass(pass), .fail(fail), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic pat(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      2:       return (c % 3) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Runs one transaction; the model tracks beats, errors and stall length from the bench's own stimulus.
  task automatic run_case(input string tag, input int n, input int dmode, input int emode,
                          input int stall_after, input int abort_after);
    int idx = 0;
    int errs = 0;
    int stall = 0;
    int c = 0;
    bit done = 1'b0;
    bit exp_pass, exp_to = 1'b0;
    bit hs, mm;
    @(negedge clk);
    start = 1'b1; num_beats = n[CW-1:0]; dut_valid = 1'b0; exp_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) done = 1'b1;
    while (!done && c < 400) begin
      @(negedge clk);
      dut_valid = pat(dmode, c);
      exp_valid = (idx >= stall_after) ? 1'b0 : pat(emode, c);
      dut_data  = dq[idx];
      exp_data  = eq[idx];
      hs = dut_valid & exp_valid;
      #1;
      check($sformatf("%s ready c%0d", tag, c), {30'd0, dut_ready, exp_ready}, {30'd0, hs, hs});
      check($sformatf("%s run c%0d", tag, c), {29'd0, busy, pass, fail}, 32'b100);
      check($sformatf("%s beats c%0d", tag, c), {16'd0, beat_count}, 32'(idx));
      @(posedge clk);
      if (hs) begin
        mm = (dq[idx] != eq[idx]);
        errs += int'(mm);
        idx++;
        stall = 0;
        if (idx == n) done = 1'b1;
        else if (STOP && mm) done = 1'b1;
      end else begin
        stall++;
        if (stall == TO) begin
          done = 1'b1;
          exp_to = 1'b1;
        end
      end
      if (abort_after > 0 && idx == abort_after) begin
        #3 reset = 1'b1;
        #1;
        check({tag, " abort"}, {26'd0, busy, pass, fail, timeout_flag, dut_ready, exp_ready}, 32'd0);
        check({tag, " abort cnt"}, {beat_count, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0; dut_valid = 1'b0; exp_valid = 1'b0;
        return;
      end
      c++;
    end
    check({tag, " finished"}, {31'd0, done}, 32'd1);
    exp_pass = !exp_to && errs == 0;
    #1;
    check({tag, " verdict"}, {28'd0, busy, pass, fail, timeout_flag},
          {28'd0, 1'b0, exp_pass, !exp_pass, exp_to});
    check({tag, " beat_count"}, {16'd0, beat_count}, 32'(idx));
    check({tag, " err_count"}, {16'd0, err_count}, 32'(errs));
    @(negedge clk);
    dut_valid = 1'b1; exp_valid = 1'b1;
    #1;
    check({tag, " idle readies"}, {29'd0, dut_ready, exp_ready, busy}, 32'd0);
    check({tag, " sticky"}, {30'd0, pass, fail}, {30'd0, exp_pass, !exp_pass});
    dut_valid = 1'b0; exp_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; num_beats = '0;
    dut_valid = 1'b1; exp_valid = 1'b1; dut_data = '0; exp_data = '0;
    @(negedge clk); #1;
    check("reset flags", {26'd0, busy, pass, fail, timeout_flag, dut_ready, exp_ready}, 32'd0);
    check("reset counters", {beat_count, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0; dut_valid = 1'b0; exp_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin dq[i] = 16'(i); eq[i] = 16'(i); end
    run_case("match", 8, 0, 0, 99, 0);

    eq[3] = 16'h00FF;
    run_case("mismatch", 8, 0, 0, 99, 0);
    eq[3] = 16'h0003;

    run_case("skew", 4, 1, 2, 99, 0);
    run_case("timeout", 4, 0, 0, 2, 0);
    run_case("zero", 0, 0, 0, 99, 0);
    run_case("reset_mid", 8, 0, 0, 99, 5);
    dq[0] = 16'hA5A5; eq[0] = 16'hA5A5; dq[1] = 16'h5A5A; eq[1] = 16'h5A5A;
    run_case("after_reset", 2, 0, 0, 99, 0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < 64; i++) begin
        dq[i] = 16'($urandom);
        eq[i] = ($urandom_range(0, 7) == 0) ? dq[i] ^ 16'($urandom_range(1, 65535)) : dq[i];
      end
      run_case($sformatf("rand%0d", r), n, 3, 3, 99, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
